// File: rtl/des_key_schedule.sv
// DES/3DES key-schedule engine: latches one or three 64-bit keys, applies PC-1
// once per key stage and streams the 16 PC-2 round subkeys per stage over a
// valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
// Optional feature macro: DES_KEY_PARITY_CHECK_EN (odd-parity key check at start).
module des_key_schedule #(
    parameter int unsigned NKEYS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [64*NKEYS-1:0]   key_i,
    input  logic                  mode_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic [47:0]           subkey_o,
    output logic                  subkey_valid_o,
    input  logic                  subkey_ready_i,
    output logic [3:0]            round_o,
    output logic [1:0]            key_idx_o,
    output logic                  stage_dec_o,
    output logic                  last_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned KeyW      = 64 * NKEYS;
    localparam logic [1:0]  LastStage = 2'(NKEYS - 1);

    // FIPS 46-3 PC-1: output bit i (1 = MSB) takes key bit Pc1Tab[i-1].
    localparam int unsigned Pc1Tab [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // FIPS 46-3 PC-2 over the 56-bit C||D value.
    localparam int unsigned Pc2Tab [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) begin
            o[55-i] = k[64-Pc1Tab[i]];
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) begin
            o[47-i] = cd[56-Pc2Tab[i]];
        end
        return o;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Stage direction: single DES follows the mode; 3DES flips the middle stage.
    function automatic logic stage_dir(input logic [1:0] s, input logic m);
        return m ^ (s == 2'd1);
    endfunction

    // Key used by stage s: K1,K2,K3 when encrypting, K3,K2,K1 when decrypting.
    function automatic logic [63:0] stage_key(input logic [KeyW-1:0] keys,
                                              input logic [1:0] s, input logic m);
        logic [1:0]      kn;
        logic [KeyW-1:0] sh;
        kn = m ? (LastStage - s) : s;
        sh = keys << {kn, 6'd0};
        return sh[KeyW-1 -: 64];
    endfunction

    // C/D for round 0 of a stage: encrypt pre-rotates by 1, decrypt starts
    // unrotated because the total rotation over 16 rounds is a full 28 bits.
    function automatic logic [55:0] stage_load(input logic [KeyW-1:0] keys,
                                               input logic [1:0] s, input logic m);
        logic [55:0] cd;
        cd = pc1(stage_key(keys, s, m));
        if (!stage_dir(s, m)) begin
            cd = {rotl28(cd[55:28], 1'b0), rotl28(cd[27:0], 1'b0)};
        end
        return cd;
    endfunction

    // Rotation before round n (1..15). The single-bit rounds are 1, 8 and 15 in
    // both directions, since the decrypt shift list is the encrypt list reversed.
    function automatic logic [55:0] step(input logic [55:0] cd, input logic dec,
                                         input logic [3:0] n);
        logic two;
        two = !((n == 4'd1) || (n == 4'd8) || (n == 4'd15));
        if (dec) begin
            return {rotr28(cd[55:28], two), rotr28(cd[27:0], two)};
        end
        return {rotl28(cd[55:28], two), rotl28(cd[27:0], two)};
    endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
    function automatic logic keys_odd_parity(input logic [KeyW-1:0] keys);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 8 * NKEYS; i++) begin
            if (!(^keys[8*i +: 8])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction
`endif

    state_e          state_q, state_d;
    logic [KeyW-1:0] key_q, key_d;
    logic            mode_q, mode_d;
    logic [55:0]     cd_q, cd_d;
    logic [3:0]      round_q, round_d;
    logic [1:0]      stage_q, stage_d;
    logic            dec_q, dec_d;
    logic            start_ok;
    logic [3:0]      round_nxt;
    logic [1:0]      stage_nxt;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic            err_q, err_d;
`endif

    assign round_nxt = round_q + 4'd1;
    assign stage_nxt = stage_q + 2'd1;

`ifdef DES_KEY_PARITY_CHECK_EN
    assign start_ok = keys_odd_parity(key_i);
`else
    assign start_ok = 1'b1;
`endif

    // Next-state logic: start/latch, per-handshake C/D advance, stage hand-off.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        mode_d  = mode_q;
        cd_d    = cd_q;
        round_d = round_q;
        stage_d = stage_q;
        dec_d   = dec_q;
`ifdef DES_KEY_PARITY_CHECK_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (start_ok) begin
                        state_d = StRun;
                        key_d   = key_i;
                        mode_d  = mode_i;
                        cd_d    = stage_load(key_i, 2'd0, mode_i);
                        round_d = 4'd0;
                        stage_d = 2'd0;
                        dec_d   = stage_dir(2'd0, mode_i);
                    end else begin
`ifdef DES_KEY_PARITY_CHECK_EN
                        err_d = 1'b1;
`endif
                    end
                end
            end
            StRun: begin
                if (subkey_ready_i) begin
                    if (round_q == 4'd15) begin
                        if (stage_q == LastStage) begin
                            // Clear the datapath so idle outputs read as zero.
                            state_d = StDone;
                            cd_d    = '0;
                            round_d = 4'd0;
                            stage_d = 2'd0;
                            dec_d   = 1'b0;
                        end else begin
                            // Next stage starts immediately: no bubble.
                            stage_d = stage_nxt;
                            round_d = 4'd0;
                            cd_d    = stage_load(key_q, stage_nxt, mode_q);
                            dec_d   = stage_dir(stage_nxt, mode_q);
                        end
                    end else begin
                        round_d = round_nxt;
                        cd_d    = step(cd_q, dec_q, round_nxt);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= '0;
            mode_q  <= 1'b0;
            cd_q    <= '0;
            round_q <= 4'd0;
            stage_q <= 2'd0;
            dec_q   <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            stage_q <= stage_d;
            dec_q   <= dec_d;
`ifdef DES_KEY_PARITY_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy_o         = (state_q != StIdle);
    assign subkey_valid_o = (state_q == StRun);
    assign subkey_o       = pc2(cd_q);
    assign round_o        = round_q;
    assign key_idx_o      = stage_q;
    assign stage_dec_o    = dec_q;
    assign last_o         = subkey_valid_o && (round_q == 4'd15) && (stage_q == LastStage);
    assign done_o         = (state_q == StDone);
`ifdef DES_KEY_PARITY_CHECK_EN
    assign err_o          = err_q;
`else
    assign err_o          = 1'b0;
`endif

endmodule
